// File: rtl/dekatron_step_sequencer.sv
// Command sequencer in front of the dekatron counter: expands STEP / LOAD / SEEK_ZERO
// commands into single counter requests and reports the final counter value.
module dekatron_step_sequencer #(
    parameter int WIDTH     = 12,
    parameter int CNT_WIDTH = 10,
    parameter int HOLDOFF   = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Cmd_Valid,
    output logic                 Cmd_Ready,
    input  logic [1:0]           Cmd_Op,
    input  logic                 Cmd_Dec,
    input  logic [CNT_WIDTH-1:0] Cmd_Count,
    input  logic [WIDTH-1:0]     Cmd_Data,
    output logic                 Cnt_Request,
    output logic                 Cnt_Dec,
    output logic                 Cnt_Set,
    output logic [WIDTH-1:0]     Cnt_In,
    input  logic                 Cnt_Ready,
    input  logic                 Cnt_Zero,
    input  logic [WIDTH-1:0]     Cnt_Out,
    output logic                 Done,
    output logic [WIDTH-1:0]     Result,
    output logic                 Hit,
    output logic                 Error,
    output logic [CNT_WIDTH-1:0] Steps
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SEEK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_HOLD   = 3'd3,
        S_WAIT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic                 dir_q;
    logic [CNT_WIDTH-1:0] count_q, step_cnt_q;
    logic [WIDTH-1:0]     data_q;
    logic [2:0]           hold_q, hold_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 accept_s, fin_hit_s, fin_err_s;

    logic                 cmd_ready_q, cmd_ready_d, req_q, req_d, dec_q, dec_d, set_q, set_d;
    logic                 done_q, done_d, hit_q, hit_d, error_q, error_d;
    logic [WIDTH-1:0]     in_q, in_d, result_q, result_d;
    logic [CNT_WIDTH-1:0] steps_q, steps_d;

    assign accept_s = Cmd_Valid & cmd_ready_q;

    // State, command latch, counters and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            dir_q       <= 1'b0;
            count_q     <= '0;
            data_q      <= '0;
            step_cnt_q  <= '0;
            hold_q      <= 3'd0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b1;
            req_q       <= 1'b0;
            dec_q       <= 1'b0;
            set_q       <= 1'b0;
            in_q        <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            hit_q       <= 1'b0;
            error_q     <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            dec_q       <= dec_d;
            set_q       <= set_d;
            in_q        <= in_d;
            done_q      <= done_d;
            result_q    <= result_d;
            hit_q       <= hit_d;
            error_q     <= error_d;
            steps_q     <= steps_d;
            if (accept_s) begin
                op_q       <= Cmd_Op;
                dir_q      <= Cmd_Dec;
                count_q    <= Cmd_Count;
                data_q     <= Cmd_Data;
                step_cnt_q <= '0;
            end else if (state_q == S_ISSUE) begin
                step_cnt_q <= step_cnt_q + CNT_WIDTH'(1);
            end else begin
                step_cnt_q <= step_cnt_q;
            end
        end
    end

    // Next-state decision; step count reaching Cmd_Count is the "remaining == 0" test
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        fin_hit_s = 1'b0;
        fin_err_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_CHECK;
                    tmo_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                case (op_q)
                    OP_STEP: state_d = (step_cnt_q == count_q) ? S_FINISH : S_ISSUE;
                    OP_LOAD: state_d = (step_cnt_q != '0) ? S_FINISH : S_ISSUE;
                    OP_SEEK: begin
                        if (Cnt_Zero) begin
                            state_d   = S_FINISH;
                            fin_hit_s = 1'b1;
                        end else if (step_cnt_q == count_q) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                    default: begin
                        state_d   = S_FINISH;
                        fin_err_s = 1'b1;
                    end
                endcase
            end
            S_ISSUE: begin
                state_d = S_HOLD;
                hold_d  = 3'd0;
                tmo_d   = '0;
            end
            // Counter lags the request by a clock, so its Ready is not trusted here
            S_HOLD: begin
                if (hold_q == 3'(HOLDOFF - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    hold_d = hold_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (Cnt_Ready) begin
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = S_FINISH;
                    fin_err_s = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output values registered alongside the state they belong to
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        req_d       = (state_d == S_ISSUE);
        done_d      = (state_d == S_FINISH);
        if (state_d == S_ISSUE) begin
            dec_d = dir_q;
            set_d = (op_q == OP_LOAD);
            in_d  = data_q;
        end else if (state_d == S_FINISH) begin
            dec_d = 1'b0;
            set_d = 1'b0;
            in_d  = in_q;
        end else begin
            dec_d = dec_q;
            set_d = set_q;
            in_d  = in_q;
        end
        if (state_d == S_FINISH) begin
            result_d = Cnt_Out;
            hit_d    = fin_hit_s;
            error_d  = fin_err_s;
            steps_d  = step_cnt_q;
        end else begin
            result_d = result_q;
            hit_d    = hit_q;
            error_d  = error_q;
            steps_d  = steps_q;
        end
    end

    assign Cmd_Ready   = cmd_ready_q;
    assign Cnt_Request = req_q;
    assign Cnt_Dec     = dec_q;
    assign Cnt_Set     = set_q;
    assign Cnt_In      = in_q;
    assign Done        = done_q;
    assign Result      = result_q;
    assign Hit         = hit_q;
    assign Error       = error_q;
    assign Steps       = steps_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench for dekatron_step_sequencer with a behavioural dekatron counter
// (wraps between 0 and TOP_VALUE) answering its requests.
module tb_dekatron_step_sequencer;
    localparam int WIDTH     = 12;
    localparam int CNT_WIDTH = 10;
    localparam int HOLDOFF   = 2;
    localparam int TIMEOUT   = 255;
    localparam logic [WIDTH-1:0] TOP_VALUE = 12'd255;

    logic                 Clk, Rst_n;
    logic                 Cmd_Valid, Cmd_Ready, Cmd_Dec;
    logic [1:0]           Cmd_Op;
    logic [CNT_WIDTH-1:0] Cmd_Count;
    logic [WIDTH-1:0]     Cmd_Data;
    logic                 Cnt_Request, Cnt_Dec, Cnt_Set, Cnt_Ready, Cnt_Zero;
    logic [WIDTH-1:0]     Cnt_In, Cnt_Out;
    logic                 Done, Hit, Error;
    logic [WIDTH-1:0]     Result;
    logic [CNT_WIDTH-1:0] Steps;

    int n_pass  = 0;
    int n_total = 0;

    dekatron_step_sequencer #(
        .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op), .Cmd_Dec(Cmd_Dec),
        .Cmd_Count(Cmd_Count), .Cmd_Data(Cmd_Data),
        .Cnt_Request(Cnt_Request), .Cnt_Dec(Cnt_Dec), .Cnt_Set(Cnt_Set), .Cnt_In(Cnt_In),
        .Cnt_Ready(Cnt_Ready), .Cnt_Zero(Cnt_Zero), .Cnt_Out(Cnt_Out),
        .Done(Done), .Result(Result), .Hit(Hit), .Error(Error), .Steps(Steps)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Counter model: Ready drops one clock after the request edge, then busy 3 clocks
    logic [WIDTH-1:0] ctr_val, ctr_init, rq_in;
    logic             ctr_rdy, ctr_lag, ctr_load, ctr_stall, rq_set, rq_dec;
    int               ctr_busy;

    assign Cnt_Ready = ctr_rdy;
    assign Cnt_Out   = ctr_val;
    assign Cnt_Zero  = (ctr_val == 12'd0);

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ctr_val <= 12'd0; ctr_rdy <= 1'b1; ctr_lag <= 1'b0; ctr_busy <= 0;
            rq_set <= 1'b0; rq_dec <= 1'b0; rq_in <= 12'd0;
        end else if (ctr_load) begin
            ctr_val <= ctr_init; ctr_rdy <= 1'b1; ctr_lag <= 1'b0; ctr_busy <= 0;
        end else if (Cnt_Request) begin
            ctr_lag <= 1'b1; rq_set <= Cnt_Set; rq_dec <= Cnt_Dec; rq_in <= Cnt_In;
        end else if (ctr_lag) begin
            ctr_lag <= 1'b0; ctr_rdy <= 1'b0; ctr_busy <= 3;
        end else if (ctr_busy > 1) begin
            ctr_busy <= ctr_busy - 1;
        end else if (ctr_busy == 1 && !ctr_stall) begin
            ctr_busy <= 0;
            ctr_rdy  <= 1'b1;
            if (rq_set)      ctr_val <= rq_in;
            else if (rq_dec) ctr_val <= (ctr_val == 12'd0) ? TOP_VALUE : ctr_val - 12'd1;
            else             ctr_val <= (ctr_val == TOP_VALUE) ? 12'd0 : ctr_val + 12'd1;
        end
    end

    // Monitor: request/done counts, last request fields, request spacing
    int               req_cnt = 0, done_cnt = 0, viol = 0, since_req = 1000;
    logic             last_set = 1'b0;
    logic [WIDTH-1:0] last_in = 12'd0;

    always @(posedge Clk) begin
        if (Done === 1'b1) done_cnt <= done_cnt + 1;
        if (Cnt_Request === 1'b1) begin
            req_cnt  <= req_cnt + 1;
            last_set <= Cnt_Set;
            last_in  <= Cnt_In;
            if (since_req < HOLDOFF + 1) viol <= viol + 1;
            since_req <= 1;
        end else if (since_req < 1000) begin
            since_req <= since_req + 1;
        end
    end

    task automatic set_ctr(input logic [WIDTH-1:0] v);
        @(negedge Clk); ctr_init = v; ctr_load = 1'b1;
        @(negedge Clk); ctr_load = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic dec, input logic [CNT_WIDTH-1:0] cnt,
                          input logic [WIDTH-1:0] data, output int lat);
        @(negedge Clk);
        Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Dec = dec; Cmd_Count = cnt; Cmd_Data = data;
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin lat = i; break; end
        end
        n_total++; if (lat == 0) $display("FAIL done_wait: no Done within 2000 cycles (op %0d)", op); else n_pass++;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Dec = 1'b0; Cmd_Count = '0; Cmd_Data = '0;
        ctr_init = 12'd0; ctr_load = 1'b0; ctr_stall = 1'b0;
        repeat (3) @(negedge Clk);
        n_total++; if (Cmd_Ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", Cmd_Ready); else n_pass++;
        n_total++; if ({Cnt_Request, Cnt_Dec, Cnt_Set, Done, Hit, Error} !== 6'b0) $display("FAIL rst_flags got %b want 000000", {Cnt_Request, Cnt_Dec, Cnt_Set, Done, Hit, Error}); else n_pass++;
        n_total++; if ({Cnt_In, Result, Steps} !== 34'd0) $display("FAIL rst_data got %h want 0", {Cnt_In, Result, Steps}); else n_pass++;
        Rst_n = 1'b1;
    endtask

    task automatic test_step_inc();
        int lat, r0, d0;
        set_ctr(12'd0); r0 = req_cnt; d0 = done_cnt;
        do_cmd(2'b00, 1'b0, 10'd5, 12'd0, lat);
        n_total++; if (Result !== 12'd5) $display("FAIL step_inc_result got %0d want 5", Result); else n_pass++;
        n_total++; if (Steps !== 10'd5) $display("FAIL step_inc_steps got %0d want 5", Steps); else n_pass++;
        n_total++; if (Error !== 1'b0) $display("FAIL step_inc_error got %b want 0", Error); else n_pass++;
        repeat (2) @(negedge Clk);
        n_total++; if (req_cnt - r0 != 5) $display("FAIL step_inc_requests got %0d want 5", req_cnt - r0); else n_pass++;
        n_total++; if (done_cnt - d0 != 1) $display("FAIL step_inc_done_pulses got %0d want 1", done_cnt - d0); else n_pass++;
        n_total++; if (Cmd_Ready !== 1'b1) $display("FAIL step_inc_ready_after got %b want 1", Cmd_Ready); else n_pass++;
    endtask

    task automatic test_step_dec_wrap();
        int lat;
        set_ctr(12'd1);
        do_cmd(2'b00, 1'b1, 10'd3, 12'd0, lat);
        n_total++; if (Result !== 12'd254) $display("FAIL step_dec_wrap_result got %0d want 254", Result); else n_pass++;
        n_total++; if (Steps !== 10'd3) $display("FAIL step_dec_wrap_steps got %0d want 3", Steps); else n_pass++;
    endtask

    task automatic test_load();
        int lat, r0;
        r0 = req_cnt;
        do_cmd(2'b01, 1'b0, 10'd0, 12'h123, lat);
        n_total++; if (Result !== 12'h123) $display("FAIL load_result got %h want 123", Result); else n_pass++;
        n_total++; if (Steps !== 10'd1) $display("FAIL load_steps got %0d want 1", Steps); else n_pass++;
        @(negedge Clk);
        n_total++; if (req_cnt - r0 != 1) $display("FAIL load_requests got %0d want 1", req_cnt - r0); else n_pass++;
        n_total++; if (last_set !== 1'b1 || last_in !== 12'h123) $display("FAIL load_req_fields got set=%b in=%h want set=1 in=123", last_set, last_in); else n_pass++;
        n_total++; if (Cnt_Set !== 1'b0) $display("FAIL load_set_after_done got %b want 0", Cnt_Set); else n_pass++;
    endtask

    task automatic test_seek_zero();
        int lat, r0;
        set_ctr(12'd7); r0 = req_cnt;
        do_cmd(2'b10, 1'b1, 10'd20, 12'd0, lat);
        n_total++; if (Steps !== 10'd7 || Hit !== 1'b1 || Result !== 12'd0) $display("FAIL seek_dec got steps=%0d hit=%b result=%0d want 7 1 0", Steps, Hit, Result); else n_pass++;
        @(negedge Clk);
        n_total++; if (req_cnt - r0 != 7) $display("FAIL seek_dec_requests got %0d want 7", req_cnt - r0); else n_pass++;
        r0 = req_cnt;
        do_cmd(2'b10, 1'b1, 10'd20, 12'd0, lat);
        @(negedge Clk);
        n_total++; if (Steps !== 10'd0 || Hit !== 1'b1 || req_cnt != r0) $display("FAIL seek_at_zero got steps=%0d hit=%b req=%0d want 0 1 0", Steps, Hit, req_cnt - r0); else n_pass++;
        n_total++; if (lat != 2) $display("FAIL seek_at_zero_latency got %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_seek_limit();
        int lat;
        set_ctr(12'd10);
        do_cmd(2'b10, 1'b0, 10'd4, 12'd0, lat);
        n_total++; if (Steps !== 10'd4 || Hit !== 1'b0 || Result !== 12'd14) $display("FAIL seek_limit got steps=%0d hit=%b result=%0d want 4 0 14", Steps, Hit, Result); else n_pass++;
    endtask

    task automatic test_step_zero_and_reserved();
        int lat, r0;
        r0 = req_cnt;
        do_cmd(2'b00, 1'b0, 10'd0, 12'd0, lat);
        n_total++; if (lat != 2 || Steps !== 10'd0) $display("FAIL step_zero got lat=%0d steps=%0d want 2 0", lat, Steps); else n_pass++;
        do_cmd(2'b11, 1'b0, 10'd3, 12'd0, lat);
        @(negedge Clk);
        n_total++; if (lat != 2 || Error !== 1'b1) $display("FAIL reserved_op got lat=%0d error=%b want 2 1", lat, Error); else n_pass++;
        n_total++; if (req_cnt != r0) $display("FAIL reserved_requests got %0d want 0", req_cnt - r0); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, r0;
        set_ctr(12'd5); ctr_stall = 1'b1; r0 = req_cnt;
        // CHECK, ISSUE, HOLDOFF hold cycles, TIMEOUT wait cycles, then FINISH
        do_cmd(2'b00, 1'b0, 10'd2, 12'd0, lat);
        n_total++; if (lat != 2 + HOLDOFF + TIMEOUT + 1) $display("FAIL timeout_latency got %0d want %0d", lat, 2 + HOLDOFF + TIMEOUT + 1); else n_pass++;
        n_total++; if (Error !== 1'b1 || Steps !== 10'd1) $display("FAIL timeout_flags got error=%b steps=%0d want 1 1", Error, Steps); else n_pass++;
        @(negedge Clk);
        n_total++; if (req_cnt - r0 != 1) $display("FAIL timeout_requests got %0d want 1", req_cnt - r0); else n_pass++;
        ctr_stall = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int d0;
        set_ctr(12'd0); ctr_stall = 1'b1;
        @(negedge Clk);
        Cmd_Valid = 1'b1; Cmd_Op = 2'b00; Cmd_Dec = 1'b0; Cmd_Count = 10'd3; Cmd_Data = 12'd0;
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
        repeat (8) @(negedge Clk);
        d0 = done_cnt;
        Rst_n = 1'b0; #1;
        n_total++; if (Cmd_Ready !== 1'b1) $display("FAIL midrst_cmd_ready got %b want 1", Cmd_Ready); else n_pass++;
        n_total++; if ({Cnt_Request, Cnt_Dec, Cnt_Set, Done, Hit, Error} !== 6'b0) $display("FAIL midrst_flags got %b want 000000", {Cnt_Request, Cnt_Dec, Cnt_Set, Done, Hit, Error}); else n_pass++;
        n_total++; if ({Cnt_In, Result, Steps} !== 34'd0) $display("FAIL midrst_data got %h want 0", {Cnt_In, Result, Steps}); else n_pass++;
        ctr_stall = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        n_total++; if (done_cnt != d0) $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_request_spacing();
        n_total++; if (viol != 0) $display("FAIL request_spacing got %0d violations want 0", viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step_inc();
        test_step_dec_wrap();
        test_load();
        test_seek_zero();
        test_seek_limit();
        test_step_zero_and_reserved();
        test_timeout();
        test_reset_mid_wait();
        test_request_spacing();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
